// File: rtl/uart_tx_param_if.sv
// ---------------------------------------------------------------------------
// uart_tx_param_if
// Purpose : write-side handshake between a word producer and the UART
//           transmitter FIFO.
// Signals : i_data  - payload word offered by the producer (DATA_BITS wide)
//           i_valid - i_data is valid this cycle
//           o_ready - the transmitter FIFO can take a word this cycle
// Modports: master - the producer (drives i_data/i_valid, sees o_ready)
//           slave  - the transmitter (sees i_data/i_valid, drives o_ready)
// ---------------------------------------------------------------------------
interface uart_tx_param_if #(
  parameter int DATA_BITS = 8
);
  logic [DATA_BITS-1:0] i_data;
  logic                 i_valid;
  logic                 o_ready;

  modport master (output i_data, output i_valid, input o_ready);
  modport slave  (input i_data, input i_valid, output o_ready);
endinterface

// File: rtl/uart_tx_param.sv
// ---------------------------------------------------------------------------
// uart_tx_param
// Purpose : parameterised UART transmitter with a small input FIFO.  Words
//           are queued through a valid/ready handshake and sent as
//           start + DATA_BITS (LSB first) + optional parity + stop bit(s).
//           Frames are sent back-to-back while the FIFO holds data.
// Ports   : i_clk  - system clock, rising edge active
//           i_rst  - synchronous active-high reset
//           s_if   - write handshake (i_data, i_valid, o_ready)
//           o_tx   - registered serial line, idle high
//           o_busy - frame in flight or FIFO non-empty
// ---------------------------------------------------------------------------
module uart_tx_param #(
  parameter int CLKS_PER_BIT = 104,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic           i_clk,
  input  logic           i_rst,
  uart_tx_param_if.slave s_if,
  output logic           o_tx,
  output logic           o_busy
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CQ_W  = PTR_W + 1;
  localparam int IDX_W = 4;

  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [IDX_W-1:0] IDX_ZERO  = {IDX_W{1'b0}};
  localparam logic [IDX_W-1:0] IDX_ONE   = IDX_W'(1);
  localparam logic [IDX_W-1:0] DATA_LAST = IDX_W'(DATA_BITS - 1);
  localparam logic [IDX_W-1:0] STOP_LAST = IDX_W'(STOP_BITS - 1);
  localparam logic [CQ_W-1:0]  CQ_ZERO   = {CQ_W{1'b0}};
  localparam logic [CQ_W-1:0]  CQ_ONE    = CQ_W'(1);
  localparam logic [CQ_W-1:0]  CQ_FULL   = CQ_W'(FIFO_DEPTH);
  localparam logic [PTR_W-1:0] PTR_ZERO  = {PTR_W{1'b0}};
  localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } state_e;

  // Parity bit of a payload word: even parity is the XOR of the bits,
  // odd parity its inverse.
  function automatic logic calc_parity(input logic [DATA_BITS-1:0] word);
    logic even_bit;
    even_bit = ^word;
    if (PARITY == 1) begin
      return ~even_bit;
    end else begin
      return even_bit;
    end
  endfunction

  state_e               state_q,   state_d;
  logic [CNT_W-1:0]     bit_cnt_q, bit_cnt_d;
  logic [IDX_W-1:0]     bit_idx_q, bit_idx_d;
  logic [DATA_BITS-1:0] shift_q,   shift_d;
  logic                 par_q,     par_d;
  logic                 tx_q,      tx_d;
  logic                 busy_q,    busy_d;
  logic                 ready_q,   ready_d;
  logic [CQ_W-1:0]      count_q,   count_d;
  logic [PTR_W-1:0]     wr_ptr_q,  wr_ptr_d;
  logic [PTR_W-1:0]     rd_ptr_q,  rd_ptr_d;
  logic [DATA_BITS-1:0] fifo_mem [FIFO_DEPTH];

  logic                 push_s;
  logic                 pop_s;
  logic                 bit_end_s;
  logic [DATA_BITS-1:0] head_s;

  // Next-state logic: FSM sequencing, FIFO pointers/count and output levels.
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    par_d     = par_q;
    pop_s     = 1'b0;
    head_s    = fifo_mem[rd_ptr_q];
    bit_end_s = (bit_cnt_q == CNT_LAST);
    // Acceptance uses the registered ready only, never a same-cycle pop.
    push_s    = s_if.i_valid & ready_q;

    case (state_q)
      ST_IDLE: begin
        bit_cnt_d = CNT_ZERO;
        if (count_q != CQ_ZERO) begin
          pop_s     = 1'b1;
          state_d   = ST_START;
          bit_idx_d = IDX_ZERO;
          shift_d   = head_s;
          par_d     = calc_parity(head_s);
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_START: begin
        if (bit_end_s) begin
          state_d   = ST_DATA;
          bit_cnt_d = CNT_ZERO;
          bit_idx_d = IDX_ZERO;
        end else begin
          bit_cnt_d = bit_cnt_q + CNT_ONE;
        end
      end
      ST_DATA: begin
        if (bit_end_s) begin
          bit_cnt_d = CNT_ZERO;
          if (bit_idx_q == DATA_LAST) begin
            bit_idx_d = IDX_ZERO;
            if (PARITY != 0) begin
              state_d = ST_PARITY;
            end else begin
              state_d = ST_STOP;
            end
          end else begin
            bit_idx_d = bit_idx_q + IDX_ONE;
            shift_d   = shift_q >> 1;
          end
        end else begin
          bit_cnt_d = bit_cnt_q + CNT_ONE;
        end
      end
      ST_PARITY: begin
        if (bit_end_s) begin
          state_d   = ST_STOP;
          bit_cnt_d = CNT_ZERO;
          bit_idx_d = IDX_ZERO;
        end else begin
          bit_cnt_d = bit_cnt_q + CNT_ONE;
        end
      end
      ST_STOP: begin
        if (bit_end_s) begin
          bit_cnt_d = CNT_ZERO;
          if (bit_idx_q == STOP_LAST) begin
            bit_idx_d = IDX_ZERO;
            // Chain straight into the next frame when data is waiting.
            if (count_q != CQ_ZERO) begin
              pop_s   = 1'b1;
              state_d = ST_START;
              shift_d = head_s;
              par_d   = calc_parity(head_s);
            end else begin
              state_d = ST_IDLE;
            end
          end else begin
            bit_idx_d = bit_idx_q + IDX_ONE;
          end
        end else begin
          bit_cnt_d = bit_cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d   = ST_IDLE;
        bit_cnt_d = CNT_ZERO;
        bit_idx_d = IDX_ZERO;
      end
    endcase

    // Pointers wrap naturally because FIFO_DEPTH is a power of two.
    if (push_s) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push_s, pop_s})
      2'b10:   count_d = count_q + CQ_ONE;
      2'b01:   count_d = count_q - CQ_ONE;
      default: count_d = count_q;
    endcase

    // The line level follows the registered state, so o_tx trails the
    // state register by one cycle.
    case (state_q)
      ST_IDLE:   tx_d = 1'b1;
      ST_START:  tx_d = 1'b0;
      ST_DATA:   tx_d = shift_q[0];
      ST_PARITY: tx_d = par_q;
      ST_STOP:   tx_d = 1'b1;
      default:   tx_d = 1'b1;
    endcase

    busy_d  = (state_d != ST_IDLE) || (count_d != CQ_ZERO);
    ready_d = (count_d != CQ_FULL);
  end

  // FSM, FIFO bookkeeping and registered outputs.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q   <= ST_IDLE;
      bit_cnt_q <= CNT_ZERO;
      bit_idx_q <= IDX_ZERO;
      shift_q   <= {DATA_BITS{1'b0}};
      par_q     <= 1'b0;
      tx_q      <= 1'b1;
      busy_q    <= 1'b0;
      ready_q   <= 1'b1;
      count_q   <= CQ_ZERO;
      wr_ptr_q  <= PTR_ZERO;
      rd_ptr_q  <= PTR_ZERO;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      par_q     <= par_d;
      tx_q      <= tx_d;
      busy_q    <= busy_d;
      ready_q   <= ready_d;
      count_q   <= count_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
    end
  end

  // FIFO storage; contents are meaningless once count/pointers are reset.
  always_ff @(posedge i_clk) begin
    if (push_s && !i_rst) begin
      fifo_mem[wr_ptr_q] <= s_if.i_data;
    end else begin
      fifo_mem[wr_ptr_q] <= fifo_mem[wr_ptr_q];
    end
  end

  assign o_tx         = tx_q;
  assign o_busy       = busy_q;
  assign s_if.o_ready = ready_q;

endmodule

// File: tb/tb_uart_tx_param.sv
// ---------------------------------------------------------------------------
// tb_uart_tx_param
// Three transmitters with different parameter sets share one stimulus
// stream; each is compared every cycle against a timeline model that
// derives the expected line level from the pop time of each frame.
//   inst0: CLKS_PER_BIT=4, 8 data bits, no parity,   1 stop, depth 4
//   inst1: CLKS_PER_BIT=4, 8 data bits, even parity, 2 stop, depth 4
//   inst2: CLKS_PER_BIT=3, 6 data bits, odd parity,  1 stop, depth 2
// ---------------------------------------------------------------------------
module tb_uart_tx_param;

  logic       clk = 1'b0;
  logic       rst;
  logic       valid;
  logic [8:0] data;
  int         errors = 0;
  int         checks = 0;
  int         cyc    = 0;

  always #5 clk = ~clk;

  uart_tx_param_if #(.DATA_BITS(8)) if0 ();
  uart_tx_param_if #(.DATA_BITS(8)) if1 ();
  uart_tx_param_if #(.DATA_BITS(6)) if2 ();

  assign if0.i_valid = valid;
  assign if1.i_valid = valid;
  assign if2.i_valid = valid;
  assign if0.i_data  = data[7:0];
  assign if1.i_data  = data[7:0];
  assign if2.i_data  = data[5:0];

  logic tx0, tx1, tx2, busy0, busy1, busy2;
  logic [2:0] tx_o, busy_o, ready_o;
  assign tx_o    = {tx2, tx1, tx0};
  assign busy_o  = {busy2, busy1, busy0};
  assign ready_o = {if2.o_ready, if1.o_ready, if0.o_ready};

  uart_tx_param #(.CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4))
    dut0 (.i_clk(clk), .i_rst(rst), .s_if(if0), .o_tx(tx0), .o_busy(busy0));
  uart_tx_param #(.CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY(2), .STOP_BITS(2), .FIFO_DEPTH(4))
    dut1 (.i_clk(clk), .i_rst(rst), .s_if(if1), .o_tx(tx1), .o_busy(busy1));
  uart_tx_param #(.CLKS_PER_BIT(3), .DATA_BITS(6), .PARITY(1), .STOP_BITS(1), .FIFO_DEPTH(2))
    dut2 (.i_clk(clk), .i_rst(rst), .s_if(if2), .o_tx(tx2), .o_busy(busy2));

  // ---------------- reference model ----------------
  function automatic int cpb(int k);
    case (k) 0: return 4; 1: return 4; default: return 3; endcase
  endfunction
  function automatic int dbits(int k);
    case (k) 0: return 8; 1: return 8; default: return 6; endcase
  endfunction
  function automatic int par(int k);
    case (k) 0: return 0; 1: return 2; default: return 1; endcase
  endfunction
  function automatic int stops(int k);
    case (k) 0: return 1; 1: return 2; default: return 1; endcase
  endfunction
  function automatic int depth(int k);
    case (k) 0: return 4; 1: return 4; default: return 2; endcase
  endfunction
  function automatic int flen(int k);
    return (1 + dbits(k) + ((par(k) != 0) ? 1 : 0) + stops(k)) * cpb(k);
  endfunction

  // Level of bit slot i of the frame carrying word w.
  function automatic logic fbit(int k, int w, int i);
    logic p;
    if (i == 0) return 1'b0;
    if (i <= dbits(k)) return 1'((w >> (i - 1)) & 1);
    if (par(k) != 0 && i == dbits(k) + 1) begin
      p = ^w;
      return (par(k) == 2) ? p : ~p;
    end
    return 1'b1;
  endfunction

  int mq0[$], mq1[$], mq2[$];
  int cur_w[3], cur_p[3], prv_w[3], prv_p[3], fend[3];
  bit cur_v[3], prv_v[3];

  function automatic int msize(int k);
    case (k) 0: return mq0.size(); 1: return mq1.size(); default: return mq2.size(); endcase
  endfunction

  task automatic mpush(int k, int w);
    case (k) 0: mq0.push_back(w); 1: mq1.push_back(w); default: mq2.push_back(w); endcase
  endtask

  task automatic mpop(int k, output int w);
    case (k) 0: w = mq0.pop_front(); 1: w = mq1.pop_front(); default: w = mq2.pop_front(); endcase
  endtask

  task automatic mclear(int k);
    case (k) 0: mq0.delete(); 1: mq1.delete(); default: mq2.delete(); endcase
  endtask

  // Apply the edge just taken (inputs as they stood at that edge).
  task automatic model_update();
    for (int k = 0; k < 3; k++) begin
      if (rst) begin
        mclear(k);
        cur_v[k] = 1'b0;
        prv_v[k] = 1'b0;
        fend[k]  = 0;
      end else begin
        int  sz;
        int  w;
        bit  do_pop;
        bit  do_push;
        sz      = msize(k);
        do_pop  = (cyc >= fend[k]) && (sz != 0);
        do_push = valid && (sz != depth(k));
        if (do_pop) begin
          prv_w[k] = cur_w[k]; prv_p[k] = cur_p[k]; prv_v[k] = cur_v[k];
          mpop(k, w);
          cur_w[k] = w; cur_p[k] = cyc; cur_v[k] = 1'b1;
          fend[k]  = cyc + flen(k);
        end
        if (do_push) mpush(k, int'(data) & ((1 << dbits(k)) - 1));
      end
    end
  endtask

  // Expected {tx, busy, ready} after the current edge.
  function automatic logic [2:0] exp_vec(int k);
    logic lvl, bsy, rdy;
    lvl = 1'b1;
    if (cur_v[k] && cyc >= cur_p[k] + 1 && cyc <= cur_p[k] + flen(k))
      lvl = fbit(k, cur_w[k], (cyc - cur_p[k] - 1) / cpb(k));
    else if (prv_v[k] && cyc >= prv_p[k] + 1 && cyc <= prv_p[k] + flen(k))
      lvl = fbit(k, prv_w[k], (cyc - prv_p[k] - 1) / cpb(k));
    bsy = (cur_v[k] && cyc < fend[k]) || (msize(k) != 0);
    rdy = (msize(k) != depth(k));
    return {lvl, bsy, rdy};
  endfunction

  task automatic step();
    @(posedge clk);
    cyc++;
    model_update();
    #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1; valid = 1'b1; data = 9'($urandom);
    repeat (3) begin
      step();
      for (int k = 0; k < 3; k++) begin
        checks++;
        if ({tx_o[k], busy_o[k], ready_o[k]} !== 3'b101) begin
          errors++;
          $display("FAIL reset inst%0d cyc%0d: tx/busy/ready got %b want 101", k, cyc, {tx_o[k], busy_o[k], ready_o[k]});
        end
      end
    end
    rst = 1'b0; valid = 1'b0;
    repeat (4) begin
      step();
      for (int k = 0; k < 3; k++) begin
        checks++;
        if ({tx_o[k], busy_o[k], ready_o[k]} !== exp_vec(k)) begin
          errors++;
          $display("FAIL reset_idle inst%0d cyc%0d: got %b want %b", k, cyc, {tx_o[k], busy_o[k], ready_o[k]}, exp_vec(k));
        end
      end
    end
  endtask

  task automatic test_single_a5();
    logic       seq [0:44];
    logic       bsy [0:44];
    logic [9:0] pat;
    pat = 10'b1101001010;  // slot i = pat[i]: 0,1,0,1,0,0,1,0,1,1
    valid = 1'b1; data = 9'h0A5;
    step();
    valid = 1'b0;
    for (int j = 0; j < 45; j++) begin
      step();
      seq[j] = tx_o[0];
      bsy[j] = busy_o[0];
      for (int k = 0; k < 3; k++) begin
        checks++;
        if ({tx_o[k], busy_o[k], ready_o[k]} !== exp_vec(k)) begin
          errors++;
          $display("FAIL single inst%0d cyc%0d: got %b want %b", k, cyc, {tx_o[k], busy_o[k], ready_o[k]}, exp_vec(k));
        end
      end
    end
    checks++;
    if (seq[0] !== 1'b1) begin
      errors++; $display("FAIL a5_latency_n1: tx got %b want 1", seq[0]);
    end
    for (int j = 1; j <= 40; j++) begin
      checks++;
      if (seq[j] !== pat[(j - 1) / 4]) begin
        errors++; $display("FAIL a5_pattern j%0d: tx got %b want %b", j, seq[j], pat[(j - 1) / 4]);
      end
    end
    checks++;
    if (bsy[39] !== 1'b1 || bsy[40] !== 1'b0) begin
      errors++; $display("FAIL a5_busy_end: busy got %b%b want 10", bsy[39], bsy[40]);
    end
  endtask

  task automatic test_parity();
    logic seq1 [0:59];
    logic seq2 [0:59];
    logic bs1  [0:59];
    repeat (20) begin
      step();
      for (int k = 0; k < 3; k++) begin
        checks++;
        if ({tx_o[k], busy_o[k], ready_o[k]} !== exp_vec(k)) begin
          errors++;
          $display("FAIL parity_settle inst%0d cyc%0d: got %b want %b", k, cyc, {tx_o[k], busy_o[k], ready_o[k]}, exp_vec(k));
        end
      end
    end
    valid = 1'b1; data = 9'h007;
    step();
    valid = 1'b0;
    for (int j = 0; j < 60; j++) begin
      step();
      seq1[j] = tx_o[1]; seq2[j] = tx_o[2]; bs1[j] = busy_o[1];
      for (int k = 0; k < 3; k++) begin
        checks++;
        if ({tx_o[k], busy_o[k], ready_o[k]} !== exp_vec(k)) begin
          errors++;
          $display("FAIL parity inst%0d cyc%0d: got %b want %b", k, cyc, {tx_o[k], busy_o[k], ready_o[k]}, exp_vec(k));
        end
      end
    end
    checks++;
    if (seq1[37] !== 1'b1) begin
      errors++; $display("FAIL even_parity_bit: got %b want 1", seq1[37]);
    end
    checks++;
    if (seq2[22] !== 1'b0) begin
      errors++; $display("FAIL odd_parity_bit: got %b want 0", seq2[22]);
    end
    checks++;
    if (bs1[47] !== 1'b1 || bs1[48] !== 1'b0) begin
      errors++; $display("FAIL two_stop_len: busy got %b%b want 10", bs1[47], bs1[48]);
    end
  endtask

  task automatic test_back_to_back();
    int busy_cnt = 0;
    logic [7:0] words [5];
    words = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (ready_o[0] !== 1'b1) begin
        errors++; $display("FAIL b2b_ready_before_push%0d: got %b want 1", i, ready_o[0]);
      end
      valid = 1'b1; data = {1'b0, words[i]};
      step();
      for (int k = 0; k < 3; k++) begin
        checks++;
        if ({tx_o[k], busy_o[k], ready_o[k]} !== exp_vec(k)) begin
          errors++;
          $display("FAIL b2b_push inst%0d cyc%0d: got %b want %b", k, cyc, {tx_o[k], busy_o[k], ready_o[k]}, exp_vec(k));
        end
      end
    end
    valid = 1'b0;
    checks++;
    if (ready_o[0] !== 1'b0) begin
      errors++; $display("FAIL b2b_ready_full: got %b want 0", ready_o[0]);
    end
    repeat (260) begin
      step();
      if (busy_o[0] === 1'b1) busy_cnt++;
      for (int k = 0; k < 3; k++) begin
        checks++;
        if ({tx_o[k], busy_o[k], ready_o[k]} !== exp_vec(k)) begin
          errors++;
          $display("FAIL b2b inst%0d cyc%0d: got %b want %b", k, cyc, {tx_o[k], busy_o[k], ready_o[k]}, exp_vec(k));
        end
      end
    end
    checks++;
    if (busy_cnt != 196) begin
      errors++; $display("FAIL b2b_no_gap: busy cycles got %0d want 196", busy_cnt);
    end
  endtask

  task automatic test_full_hold();
    valid = 1'b1;
    repeat (150) begin
      data = 9'($urandom);
      step();
      for (int k = 0; k < 3; k++) begin
        checks++;
        if ({tx_o[k], busy_o[k], ready_o[k]} !== exp_vec(k)) begin
          errors++;
          $display("FAIL full_hold inst%0d cyc%0d: got %b want %b", k, cyc, {tx_o[k], busy_o[k], ready_o[k]}, exp_vec(k));
        end
      end
    end
    valid = 1'b0;
    repeat (260) begin
      step();
      for (int k = 0; k < 3; k++) begin
        checks++;
        if ({tx_o[k], busy_o[k], ready_o[k]} !== exp_vec(k)) begin
          errors++;
          $display("FAIL full_drain inst%0d cyc%0d: got %b want %b", k, cyc, {tx_o[k], busy_o[k], ready_o[k]}, exp_vec(k));
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      data = 9'($urandom);
      step();
    end
    valid = 1'b0;
    repeat (15) step();   // inst0 is now in data bit 3
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      checks++;
      if ({tx_o[k], busy_o[k], ready_o[k]} !== 3'b101) begin
        errors++;
        $display("FAIL reset_mid inst%0d: tx/busy/ready got %b want 101", k, {tx_o[k], busy_o[k], ready_o[k]});
      end
    end
    repeat (80) begin
      step();
      for (int k = 0; k < 3; k++) begin
        checks++;
        if ({tx_o[k], busy_o[k], ready_o[k]} !== exp_vec(k)) begin
          errors++;
          $display("FAIL reset_mid_after inst%0d cyc%0d: got %b want %b", k, cyc, {tx_o[k], busy_o[k], ready_o[k]}, exp_vec(k));
        end
      end
    end
  endtask

  task automatic test_random();
    int rate = 10;
    for (int n = 0; n < 3000; n++) begin
      if (n % 500 == 0) rate = int'($urandom_range(2, 90));
      valid = ($urandom_range(0, 99) < rate);
      data  = 9'($urandom);
      rst   = ($urandom_range(0, 799) == 0);
      step();
      for (int k = 0; k < 3; k++) begin
        checks++;
        if ({tx_o[k], busy_o[k], ready_o[k]} !== exp_vec(k)) begin
          errors++;
          $display("FAIL random inst%0d cyc%0d: got %b want %b", k, cyc, {tx_o[k], busy_o[k], ready_o[k]}, exp_vec(k));
        end
      end
    end
    rst = 1'b0; valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; valid = 1'b0; data = 9'h000;
    for (int k = 0; k < 3; k++) begin
      cur_v[k] = 1'b0; prv_v[k] = 1'b0; fend[k] = 0;
      cur_w[k] = 0; cur_p[k] = 0; prv_w[k] = 0; prv_p[k] = 0;
    end
    test_reset();
    test_single_a5();
    test_parity();
    test_back_to_back();
    test_full_hold();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_tx_param.md
UART_TX_PARAM -- requirements
Module: uart_tx_param

Interface
REQ-001 The block SHALL have parameter CLKS_PER_BIT, default 104, giving i_clk cycles per serial bit (legal range 2..65535).
REQ-002 The block SHALL have parameter DATA_BITS, default 8, giving payload bits per frame (legal range 5..9).
REQ-003 The block SHALL have parameter PARITY, default 0, selecting 0 = none, 1 = odd, 2 = even.
REQ-004 The block SHALL have parameter STOP_BITS, default 1, with legal values 1 or 2.
REQ-005 The block SHALL have parameter FIFO_DEPTH, default 4, a power of two in the range 2..64.
REQ-006 The block SHALL have port i_clk, input, 1 bit: the single system clock; all state changes occur on its rising edge.
REQ-007 The block SHALL have port i_rst, input, 1 bit: synchronous, active-high reset.
REQ-008 The block SHALL have port i_data, input, DATA_BITS wide: the payload word to enqueue.
REQ-009 The block SHALL have port i_valid, input, 1 bit: i_data is valid this cycle.
REQ-010 The block SHALL have port o_ready, output, 1 bit: the FIFO can accept a word this cycle.
REQ-011 The block SHALL have port o_tx, output, 1 bit: the registered serial line, idle high.
REQ-012 The block SHALL have port o_busy, output, 1 bit: a frame is in flight or the FIFO is non-empty.

Function
REQ-013 A word SHALL be pushed into the FIFO on a rising edge where i_valid=1 and o_ready=1; with i_valid=1 and o_ready=0 the word SHALL be dropped, with no state change.
REQ-014 o_ready SHALL equal (FIFO count != FIFO_DEPTH) and SHALL depend only on registered count, not on a same-cycle pop.
REQ-015 The FSM SHALL have states IDLE, START, DATA, PARITY, STOP.
REQ-016 In IDLE with the FIFO non-empty, the FSM SHALL pop the head word on the next edge and enter START.
REQ-017 A word accepted at edge N into an empty FIFO with the FSM in IDLE SHALL drive o_tx=0 from edge N+2.
REQ-018 Each serial bit SHALL last exactly CLKS_PER_BIT cycles, timed by a bit counter that is reset on every state entry.
REQ-019 The frame SHALL be sent in this order: start bit (0), then DATA_BITS bits LSB first, then the parity bit if PARITY!=0, then STOP_BITS stop bits (1).
REQ-020 The even-parity bit SHALL equal the XOR of the data bits, and the odd-parity bit SHALL equal its inverse; with PARITY=0 the FSM SHALL go from DATA directly to STOP.
REQ-021 A frame SHALL span exactly (1 + DATA_BITS + (PARITY!=0) + STOP_BITS) * CLKS_PER_BIT cycles.
REQ-022 At the last cycle of the final stop bit, the FSM SHALL enter START directly if the FIFO is non-empty (popping the next word, no idle gap), and IDLE otherwise.
REQ-023 A push and a pop in the same cycle SHALL leave the count unchanged and preserve FIFO order; read and write pointers SHALL wrap modulo FIFO_DEPTH.
REQ-024 The transmitted word SHALL be latched into a shift register on pop, so FIFO writes during a frame SHALL NOT alter the frame in flight.
REQ-025 o_busy SHALL be 1 whenever the state != IDLE or the count != 0, and 0 otherwise.

Reset
REQ-026 On any edge with i_rst=1, the block SHALL set state=IDLE, o_tx=1, the FIFO count and both pointers to 0, and the bit counter to 0, so that o_ready=1 and o_busy=0 on the following cycle.
REQ-027 A reset during a frame SHALL abort the frame immediately, discard all FIFO contents, and return o_tx high on the next cycle.
REQ-028 A push presented during reset SHALL be ignored.

Verification
REQ-029 With CLKS_PER_BIT=4, DATA_BITS=8, PARITY=0, STOP_BITS=1, push 0xA5 -> o_tx shall read 0,1,0,1,0,0,1,0,1,1, each level held 4 cycles, with o_busy=1 for 40 cycles and then 0.
REQ-030 With PARITY=2, push 0x07, then with PARITY=1 push 0x07 -> the parity bit shall be 1 for even and 0 for odd; with STOP_BITS=2 the stop level shall last 8 cycles.
REQ-031 With FIFO_DEPTH=4, push 0x11, 0x22, 0x33, 0x44, 0x55 on consecutive cycles -> after the first pop, 0x11 to 0x55 shall all be accepted, o_ready shall drop only when the count is 4, and the five frames shall be sent back-to-back with no idle cycles between them.
REQ-032 Hold i_valid=1 while full -> no word shall be accepted and the count shall stay 4 until the next pop frees a slot.
REQ-033 Assert i_rst for 1 cycle mid data bit 3 with 2 words queued -> on the next cycle o_tx=1, o_busy=0, o_ready=1, and no further frames shall be sent.
REQ-034 A push accepted at edge N with the block idle -> o_tx shall fall at edge N+2.
